// File: rtl/acc_stream_pkg.sv
// Shared widths and the lane-array view of a packed 32-bit sample word
// for the acc_pipe host bridge.
package acc_stream_pkg;
  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int WORD_W = 32;
  localparam int NV_W   = 3;

  typedef logic signed [DATA_W-1:0] lane_t;
  typedef lane_t [LANES-1:0] sample_t;

  function automatic sample_t to_sample(input logic [WORD_W-1:0] w);
    return sample_t'(w);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head is visible combinationally, flags come
// from the occupancy register, writes while full are dropped.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_wr, do_rd;

  assign full    = (count_reg == DEPTH_CNT);
  assign empty   = (count_reg == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage needs no reset: the owner masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

// File: rtl/acc_stream_bridge.sv
// Host endpoint for acc_pipe: queues packed samples towards X1..X4 and packs
// returned Y results four per word into a host-readable result FIFO.
module acc_stream_bridge
  import acc_stream_pkg::*;
#(
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_wr_en,
  input  logic [WORD_W-1:0]        in_wdata,
  output logic                     in_full,
  output logic                     in_ovf,
  output logic signed [DATA_W-1:0] X1,
  output logic signed [DATA_W-1:0] X2,
  output logic signed [DATA_W-1:0] X3,
  output logic signed [DATA_W-1:0] X4,
  output logic                     valid,
  input  logic                     ready,
  input  logic signed [DATA_W-1:0] Y,
  input  logic                     valid_out,
  output logic                     ready_out,
  input  logic                     pack_flush,
  input  logic                     out_rd_en,
  output logic [WORD_W-1:0]        out_rdata,
  output logic [NV_W-1:0]          out_nvalid,
  output logic                     out_empty,
  output logic [CNT_W-1:0]         sent_cnt,
  output logic [CNT_W-1:0]         recv_cnt
);
  localparam int LW = $clog2(LANES);

  logic [WORD_W-1:0]      smp_head;
  logic                   smp_empty, tx_fire;
  sample_t                head_s;
  logic                   in_ovf_reg;
  logic [CNT_W-1:0]       sent_cnt_reg, recv_cnt_reg;

  sample_t                lanes_reg, lanes_acc;
  logic [NV_W-1:0]        lane_cnt_reg, cnt_acc;
  logic                   flush_pending_reg;
  logic                   rx_fire, flush_req, word_done, res_push;
  logic                   res_full, res_empty;
  logic [NV_W+WORD_W-1:0] res_wdata, res_rdata;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(IN_DEPTH)) u_sample_fifo (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (in_wr_en),
    .wr_data (in_wdata),
    .rd_en   (tx_fire),
    .rd_data (smp_head),
    .full    (in_full),
    .empty   (smp_empty)
  );

  assign valid   = ~smp_empty;
  assign tx_fire = valid & ready;
  assign head_s  = valid ? to_sample(smp_head) : '0;
  assign X1      = head_s[0];
  assign X2      = head_s[1];
  assign X3      = head_s[2];
  assign X4      = head_s[3];
  assign in_ovf  = in_ovf_reg;

  // Lane view after this cycle's accept, so a flush sees a same-cycle Y.
  assign ready_out = ~res_full & ~flush_pending_reg;
  assign rx_fire   = valid_out & ready_out;

  always_comb begin
    lanes_acc = lanes_reg;
    cnt_acc   = lane_cnt_reg;
    if (rx_fire) begin
      lanes_acc[lane_cnt_reg[LW-1:0]] = Y;
      cnt_acc = lane_cnt_reg + NV_W'(1);
    end
  end

  assign word_done = (cnt_acc == NV_W'(LANES));
  assign flush_req = (pack_flush | flush_pending_reg) & (cnt_acc != '0);
  assign res_push  = word_done | (flush_req & ~res_full);
  assign res_wdata = {cnt_acc, lanes_acc};

  sync_fifo #(.WIDTH(NV_W + WORD_W), .DEPTH(OUT_DEPTH)) u_result_fifo (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (res_push),
    .wr_data (res_wdata),
    .rd_en   (out_rd_en),
    .rd_data (res_rdata),
    .full    (res_full),
    .empty   (res_empty)
  );

  assign out_rdata  = res_empty ? '0 : res_rdata[WORD_W-1:0];
  assign out_nvalid = res_empty ? '0 : res_rdata[WORD_W +: NV_W];
  assign out_empty  = res_empty;
  assign sent_cnt   = sent_cnt_reg;
  assign recv_cnt   = recv_cnt_reg;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      in_ovf_reg        <= 1'b0;
      sent_cnt_reg      <= '0;
      recv_cnt_reg      <= '0;
      lanes_reg         <= '0;
      lane_cnt_reg      <= '0;
      flush_pending_reg <= 1'b0;
    end else begin
      if (in_wr_en & in_full) in_ovf_reg <= 1'b1;
      sent_cnt_reg <= sent_cnt_reg + CNT_W'(tx_fire);
      recv_cnt_reg <= recv_cnt_reg + CNT_W'(rx_fire);
      if (res_push) begin
        lanes_reg         <= '0;
        lane_cnt_reg      <= '0;
        flush_pending_reg <= 1'b0;
      end else begin
        lanes_reg    <= lanes_acc;
        lane_cnt_reg <= cnt_acc;
        // A flush that found the result FIFO full waits here for space.
        if (flush_req) flush_pending_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_acc_stream_bridge.sv
// Directed and randomized stimulus for acc_stream_bridge, checked every cycle
// against a queue-based reference model of both FIFOs and the result packer.
module tb_acc_stream_bridge;
  import acc_stream_pkg::*;

  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 4;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              arst;
  logic              in_wr_en, ready, valid_out, pack_flush, out_rd_en;
  logic [31:0]       in_wdata;
  logic signed [7:0] Y;
  logic              in_full, in_ovf, valid, ready_out, out_empty;
  logic signed [7:0] X1, X2, X3, X4;
  logic [31:0]       out_rdata;
  logic [2:0]        out_nvalid;
  logic [CNT_W-1:0]  sent_cnt, recv_cnt;

  always #5 clk = ~clk;

  acc_stream_bridge #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst),
    .in_wr_en(in_wr_en), .in_wdata(in_wdata), .in_full(in_full), .in_ovf(in_ovf),
    .X1(X1), .X2(X2), .X3(X3), .X4(X4), .valid(valid), .ready(ready),
    .Y(Y), .valid_out(valid_out), .ready_out(ready_out), .pack_flush(pack_flush),
    .out_rd_en(out_rd_en), .out_rdata(out_rdata), .out_nvalid(out_nvalid),
    .out_empty(out_empty), .sent_cnt(sent_cnt), .recv_cnt(recv_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain queues, acting on pre-edge occupancy.
  logic [31:0]      m_sq[$];
  logic [7:0]       m_part[$];
  logic [34:0]      m_rq[$];
  bit               m_ovf, m_pend;
  logic [CNT_W-1:0] m_sent, m_recv;

  function automatic void m_reset();
    m_sq.delete(); m_part.delete(); m_rq.delete();
    m_ovf = 0; m_pend = 0; m_sent = '0; m_recv = '0;
  endfunction

  function automatic logic [34:0] pack_word(input logic [7:0] p[$]);
    logic [31:0] d;
    d = '0;
    foreach (p[i]) d[8*i +: 8] = p[i];
    return {3'(p.size()), d};
  endfunction

  task automatic model_step();
    bit sfull, sempty, rfull, rempty, acc;
    logic [7:0] np[$];
    sfull  = (m_sq.size() == IN_DEPTH);
    sempty = (m_sq.size() == 0);
    rfull  = (m_rq.size() == OUT_DEPTH);
    rempty = (m_rq.size() == 0);
    acc    = valid_out && !rfull && !m_pend;
    np     = m_part;
    if (ready && !sempty) begin
      $display("tx sample=%08h", m_sq[0]);
      void'(m_sq.pop_front());
      m_sent++;
    end
    if (in_wr_en) begin
      if (sfull) m_ovf = 1;
      else m_sq.push_back(in_wdata);
    end
    if (out_rd_en && !rempty) begin
      $display("host read word=%08h nvalid=%0d", m_rq[0][31:0], m_rq[0][34:32]);
      void'(m_rq.pop_front());
    end
    if (acc) begin
      np.push_back(Y);
      m_recv++;
    end
    if (np.size() == 4 || ((pack_flush || m_pend) && np.size() > 0 && !rfull)) begin
      m_rq.push_back(pack_word(np));
      np.delete();
      m_pend = 0;
    end else if ((pack_flush || m_pend) && np.size() > 0) begin
      m_pend = 1;
    end
    m_part = np;
  endtask

  task automatic check_outputs(input string ph);
    logic [31:0] mx;
    logic [34:0] mr;
    mx = (m_sq.size() != 0) ? m_sq[0] : 32'h0;
    mr = (m_rq.size() != 0) ? m_rq[0] : 35'h0;
    chk({ph, ".valid"},     valid,              m_sq.size() != 0);
    chk({ph, ".x"},         {X4, X3, X2, X1},   mx);
    chk({ph, ".in_full"},   in_full,            m_sq.size() == IN_DEPTH);
    chk({ph, ".in_ovf"},    in_ovf,             m_ovf);
    chk({ph, ".ready_out"}, ready_out,          (m_rq.size() < OUT_DEPTH) && !m_pend);
    chk({ph, ".out_empty"}, out_empty,          m_rq.size() == 0);
    chk({ph, ".out_rdata"}, out_rdata,          mr[31:0]);
    chk({ph, ".nvalid"},    out_nvalid,         mr[34:32]);
    chk({ph, ".sent_cnt"},  sent_cnt,           m_sent);
    chk({ph, ".recv_cnt"},  recv_cnt,           m_recv);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle_inputs();
    in_wr_en = 0; ready = 0; valid_out = 0; pack_flush = 0; out_rd_en = 0;
  endtask

  task automatic do_reset(input bit first);
    idle_inputs();
    arst = 1'b0;
    #2;
    m_reset();
    if (!first) check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst");
    arst = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [3];
    logic [31:0] last_data;
    logic [2:0]  last_nv;
    logic [7:0]  ys [4];
    int          n, guard;

    idle_inputs();
    in_wdata = '0;
    Y        = '0;
    do_reset(1);

    // Single sample: visible one cycle after the write, consumed the next edge.
    in_wr_en = 1; in_wdata = 32'h04FD0201; ready = 1;
    cyc();
    in_wr_en = 0;
    chk("t1_valid", valid, 1'b1);
    chk("t1_x1", {X1}, 8'h01);
    chk("t1_x2", {X2}, 8'h02);
    chk("t1_x3", {X3}, 8'hFD);
    chk("t1_x4", {X4}, 8'h04);
    cyc();
    chk("t1_sent", sent_cnt, 4'd1);
    chk("t1_valid_after", valid, 1'b0);

    // Backpressure: head held stable, then in-order transfers.
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_wr_en = 1; in_wdata = $urandom; words[i] = in_wdata;
      cyc();
    end
    in_wr_en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t2_hold_x", {X4, X3, X2, X1}, words[0]);
      chk("t2_hold_valid", valid, 1'b1);
    end
    ready = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_order", {X4, X3, X2, X1}, words[i]);
      cyc();
    end
    chk("t2_sent", sent_cnt, 4'd4);
    ready = 0;

    // Overflow: ninth write dropped, sticky flag set, exactly eight drain.
    do_reset(0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("t3_ovf_before", in_ovf, 1'b0);
      in_wr_en = 1; in_wdata = $urandom;
      cyc();
      if (i == 7) chk("t3_full_at8", in_full, 1'b1);
    end
    in_wr_en = 0;
    chk("t3_ovf", in_ovf, 1'b1);
    ready = 1; n = 0; guard = 0;
    while (valid && guard < 20) begin
      cyc();
      n++; guard++;
    end
    ready = 0;
    chk("t3_drain_count", n, 8);
    chk("t3_sent", sent_cnt, 4'd8);

    // Four results pack into one full word.
    do_reset(0);
    ys[0] = 8'd5; ys[1] = 8'hFF; ys[2] = 8'd7; ys[3] = 8'd127;
    valid_out = 1;
    for (int i = 0; i < 4; i++) begin
      Y = ys[i];
      cyc();
    end
    valid_out = 0;
    chk("t4_rdata", out_rdata, 32'h7F07FF05);
    chk("t4_nvalid", out_nvalid, 3'd4);
    chk("t4_recv", recv_cnt, 4'd4);
    out_rd_en = 1;
    cyc();
    out_rd_en = 0;
    chk("t4_empty", out_empty, 1'b1);

    // Flush alongside the second accept.
    valid_out = 1; Y = 8'h80;
    cyc();
    Y = 8'd3; pack_flush = 1;
    cyc();
    valid_out = 0; pack_flush = 0;
    chk("t5_rdata", out_rdata, 32'h00000380);
    chk("t5_nvalid", out_nvalid, 3'd2);
    out_rd_en = 1;
    cyc();
    out_rd_en = 0;

    // Fill the result FIFO; empty flush has no effect; pop reopens ready_out.
    valid_out = 1;
    for (int i = 0; i < 16; i++) begin
      Y = 8'($urandom);
      cyc();
    end
    valid_out = 0;
    chk("t6_full_ready", ready_out, 1'b0);
    pack_flush = 1;
    cyc();
    pack_flush = 0;
    chk("t6_noop_flush_ready", ready_out, 1'b0);
    out_rd_en = 1;
    cyc();
    out_rd_en = 0;
    chk("t6_pop_ready", ready_out, 1'b1);
    valid_out = 1; Y = 8'h11;
    cyc();
    Y = 8'h22; pack_flush = 1;
    cyc();
    idle_inputs();
    last_data = '0; last_nv = '0; guard = 0;
    while (!out_empty && guard < 10) begin
      last_data = out_rdata; last_nv = out_nvalid;
      out_rd_en = 1;
      cyc();
      guard++;
    end
    out_rd_en = 0;
    chk("t6_partial_data", last_data, 32'h00002211);
    chk("t6_partial_nvalid", last_nv, 3'd2);

    // Reset mid-stream discards samples, results and partial lanes.
    for (int i = 0; i < 3; i++) begin
      in_wr_en = 1; in_wdata = $urandom;
      cyc();
    end
    in_wr_en = 0; valid_out = 1;
    for (int i = 0; i < 6; i++) begin
      Y = 8'($urandom);
      cyc();
    end
    do_reset(0);
    valid_out = 1;
    for (int i = 1; i <= 4; i++) begin
      Y = 8'(i);
      cyc();
    end
    valid_out = 0;
    chk("t7_clean_word", out_rdata, 32'h04030201);
    chk("t7_clean_recv", recv_cnt, 4'd4);
    out_rd_en = 1;
    cyc();
    out_rd_en = 0;

    // Randomized traffic; 4-bit counters wrap many times here.
    for (int i = 0; i < 1500; i++) begin
      in_wr_en   = 1'($urandom_range(0, 1));
      in_wdata   = $urandom;
      ready      = ($urandom_range(0, 9) < 6);
      valid_out  = ($urandom_range(0, 9) < 6);
      Y          = 8'($urandom);
      pack_flush = ($urandom_range(0, 9) == 0);
      out_rd_en  = ($urandom_range(0, 9) < 4);
      cyc();
    end
    idle_inputs();
    ready = 1; out_rd_en = 1; pack_flush = 1;
    for (int i = 0; i < 12; i++) cyc();
    idle_inputs();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
